// File: rtl/ic_shift_recirc.sv
// Recirculating shift-register bank (WIDTH channels x DEPTH stages) built as a RAM plus tail pointer.
// Optional power-on clear sweep is enabled with `define IC_SHIFT_RECIRC_CLEAR_EN.
module ic_shift_recirc #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 1024,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [PW-1:0]    pos,
  output logic             wrap,
  output logic             busy
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    pos_q, pos_d, nxt;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, busy_d;
  logic             we;
  logic [WIDTH-1:0] wdata;

  function automatic logic [PW-1:0] next_pos(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    nxt    = next_pos(pos_q);
    pos_d  = pos_q;
    dout_d = dout_q;
    wrap_d = 1'b0;
    busy_d = busy_q;
    we     = 1'b0;
    wdata  = din;
    if (busy_q) begin
      // Clear sweep: one zero write per cycle, shift_en ignored, no wrap pulse.
      we    = 1'b1;
      wdata = '0;
      pos_d = nxt;
      if (pos_q == LAST) begin
        busy_d = 1'b0;
        dout_d = '0;
      end
    end else if (shift_en) begin
      // Recirculation leaves S[pos] untouched, so only a load needs a write.
      we     = load;
      pos_d  = nxt;
      wrap_d = (pos_q == LAST);
      dout_d = mem_q[nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q  <= '0;
      dout_q <= '0;
      wrap_q <= 1'b0;
`ifdef IC_SHIFT_RECIRC_CLEAR_EN
      busy_q <= 1'b1;
`else
      busy_q <= 1'b0;
`endif
    end else begin
      pos_q  <= pos_d;
      dout_q <= dout_d;
      wrap_q <= wrap_d;
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[pos_q] <= wdata;
  end

  assign dout = dout_q;
  assign pos  = pos_q;
  assign wrap = wrap_q;
  assign busy = busy_q;

endmodule

// File: doc/ic_shift_recirc.md
Name: ic_shift_recirc

Overview:
- Parametrised recirculating shift-register bank, WIDTH parallel channels by DEPTH stages.
- Successor to our discrete TTL models. Covers the Signetics 2504 (1024-bit dynamic shift register, six channels in parallel) used as the Apple-1 character memory, and the 2519 line buffer.
- Adds a stage-position counter, a wrap pulse and a load/recirculate mode.
- Sits between the cursor/write logic and the character generator in the video terminal.

Parameters:
- WIDTH, 6, number of parallel channels (bits per character).
- DEPTH, 1024, stages per channel; legal range 2..4096.
- PW, $clog2(DEPTH), width of pos; derived, do not override.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- shift_en  input  1  advance the register by one stage this cycle.
- load  input  1  when shift_en=1: 1 = din enters the head, 0 = tail recirculates into the head.
- din  input  WIDTH  data entering the head when load=1.
- dout  output  WIDTH  current tail stage, the value that leaves on the next shift.
- pos  output  PW  index of the stage currently at the tail, 0..DEPTH-1.
- wrap  output  1  one-cycle pulse when pos wraps from DEPTH-1 to 0.
- busy  output  1  clear sweep in progress (see Optional Feature); tied 0 otherwise.

Behaviour:
- Model: circular store S[0..DEPTH-1] with pointer pos. dout always presents S[pos]. A RAM-plus-pointer implementation is required; no physical shift chain.
- Reset (rst=1 at an edge): pos<=0, wrap<=0, dout<=0, busy<=0. S contents are not cleared (undefined in sim as X is acceptable) unless the optional feature is enabled. rst overrides shift_en, load and din in the same cycle.
- Shift edge (shift_en=1, rst=0):
  - S[pos] <= load ? din : S[pos].
  - pos <= (pos==DEPTH-1) ? 0 : pos+1.
  - After the edge, dout == S[new pos], i.e. one-cycle registered read with next-address prefetch. No extra latency between consecutive shifts.
- Hold edge (shift_en=0): S, pos and dout unchanged. wrap<=0. load and din are ignored.
- wrap <= 1 exactly on the shift edge where pos goes DEPTH-1 -> 0; otherwise 0. It is never high for two consecutive cycles unless DEPTH==1, which is illegal.
- Delay: a value loaded at pos=k reappears on dout after exactly DEPTH shift edges. Every non-load shift preserves the value.
- First edge after reset with shift_en=0: dout stays 0. It is not required to show S[0] until the first shift, or until the sweep ends if the feature is enabled.
- Back-to-back load and recirculate shifts intermix freely; the mode is evaluated per edge.
- No arithmetic beyond the modulo-DEPTH pointer increment. DEPTH need not be a power of two; the wrap compare is against DEPTH-1, not all-ones.

Optional Feature:
- Macro: IC_SHIFT_RECIRC_CLEAR_EN.
- With it defined:
  - A reset edge starts a clear sweep. busy<=1 and pos<=0.
  - On each following cycle the block writes S[pos]<=0 and advances pos, ignoring shift_en.
  - After DEPTH writes, on the edge where pos wraps to 0: busy<=0, dout<=0, wrap stays 0 throughout.
  - Reasserting rst mid-sweep restarts the sweep at pos 0.
  - Normal shifting resumes on the first edge with busy=0.
- Without it: no sweep, busy is constant 0, and S contents after reset are undefined.

Test Plan:
- DEPTH=8, WIDTH=6: reset, then 8 load shifts with din=0x01..0x08, then 8 recirculate shifts -> dout sequence 0x01..0x08 during recirculation, repeating on a second lap. wrap is high exactly once per 8 shifts, on the edge into pos=0.
- DEPTH=8: fill 0x10..0x17, shift_en low for 5 cycles with load=1, din=0x3F -> dout, pos and wrap are frozen, and contents are unchanged on the next lap.
- DEPTH=8: at pos=3 do one load with din=0x2A, then recirculate -> 0x2A reappears on dout exactly 8 shifts later at pos=3. Other slots are unchanged.
- DEPTH=1024: shift 1023 times -> pos=1023 and wrap=0. The next shift gives pos=0 and wrap=1 for one cycle. DEPTH=5 (non-power-of-two) gives the wrap after 5 shifts.
- Mid-run rst with shift_en=1 at pos=6 -> next cycle pos=0, dout=0, wrap=0. No write occurs on the reset edge.
- With IC_SHIFT_RECIRC_CLEAR_EN, DEPTH=8: fill 0x3F, pulse rst -> busy high for 8 cycles and then low. Recirculating 8 shifts gives dout=0x00 throughout. rst at sweep cycle 4 restarts the sweep, giving a total of 8 busy cycles after the second reset.
